// File: rtl/mmio_data_memory.sv
// Memory-mapped data subsystem: word RAM plus GPIO_CH GPIO channels behind one decoder,
// with a one-cycle registered read port, edge-capture interrupts and pad drivers.
module mmio_data_memory #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 32,
  parameter int GPIO_CH   = 2,
  parameter int IO_W      = 32,
  parameter int GPIO_BASE = 32
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [31:0]               i_A,
  input  logic                      i_WE,
  input  logic                      i_RE,
  input  logic [DATA_W-1:0]         i_D,
  output logic [DATA_W-1:0]         o_D,
  output logic                      o_Valid,
  output logic                      o_Err,
  input  logic [GPIO_CH*IO_W-1:0]   i_Pin,
  output logic [GPIO_CH*IO_W-1:0]   o_Pin,
  output logic [GPIO_CH*IO_W-1:0]   o_PinOE,
  output logic                      o_Irq
);
  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] RAM_END = 33'(DEPTH);
  localparam logic [32:0] GPIO_LO = 33'(GPIO_BASE);
  localparam logic [32:0] IE_ADDR = 33'(GPIO_BASE) + 33'(4 * GPIO_CH);

  // Decode in 33 bits so the upper bound of the GPIO window can never wrap.
  logic [32:0] addr_ext;
  logic        ram_hit, gpio_hit, ie_hit, mapped;
  logic        wr_en, rd_en;
  logic [31:0] gpio_off;

  assign addr_ext = {1'b0, i_A};
  assign ram_hit  = addr_ext < RAM_END;
  assign gpio_hit = (addr_ext >= GPIO_LO) && (addr_ext < IE_ADDR);
  assign ie_hit   = addr_ext == IE_ADDR;
  assign mapped   = ram_hit | gpio_hit | ie_hit;
  assign gpio_off = i_A - GPIO_LO[31:0];
  assign wr_en    = i_WE;
  assign rd_en    = i_RE & ~i_WE;

  logic [DATA_W-1:0] ram_reg [DEPTH];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) ram_reg[i] <= '0;
    end else if (wr_en && ram_hit) begin
      ram_reg[i_A[AW-1:0]] <= i_D;
    end
  end

  logic [GPIO_CH-1:0][IO_W-1:0] dir_all, out_all, in_all, isr_all;
  logic [GPIO_CH-1:0]           ie_reg, ch_irq;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                ie_reg <= '0;
    else if (wr_en && ie_hit) ie_reg <= i_D[GPIO_CH-1:0];
  end

  generate
    for (genvar gi = 0; gi < GPIO_CH; gi++) begin : g_ch
      logic [IO_W-1:0] dir_reg, out_reg, isr_reg, s1_reg, s2_reg, h_reg;
      logic [IO_W-1:0] rise, isr_clr;
      logic            sel;

      assign sel     = gpio_hit && (gpio_off[31:2] == 30'(gi));
      assign rise    = s2_reg & ~h_reg & ~dir_reg;
      assign isr_clr = (wr_en && sel && gpio_off[1:0] == 2'd3) ? i_D[IO_W-1:0] : '0;

      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          dir_reg <= '0;
          out_reg <= '0;
          isr_reg <= '0;
          s1_reg  <= '0;
          s2_reg  <= '0;
          h_reg   <= '0;
        end else begin
          s1_reg  <= i_Pin[gi*IO_W +: IO_W];
          s2_reg  <= s1_reg;
          h_reg   <= s2_reg;
          // A fresh edge wins over a simultaneous write-one-to-clear.
          isr_reg <= (isr_reg & ~isr_clr) | rise;
          if (wr_en && sel && gpio_off[1:0] == 2'd0) dir_reg <= i_D[IO_W-1:0];
          if (wr_en && sel && gpio_off[1:0] == 2'd1) out_reg <= i_D[IO_W-1:0];
        end
      end

      assign dir_all[gi] = dir_reg;
      assign out_all[gi] = out_reg;
      assign in_all[gi]  = s2_reg;
      assign isr_all[gi] = isr_reg;
      assign ch_irq[gi]  = ie_reg[gi] & (|isr_reg);
      assign o_Pin[gi*IO_W +: IO_W]   = out_reg;
      assign o_PinOE[gi*IO_W +: IO_W] = dir_reg;
    end
  endgenerate

  logic [DATA_W-1:0] rd_data;

  always_comb begin
    rd_data = '0;
    if (ram_hit) begin
      rd_data = ram_reg[i_A[AW-1:0]];
    end else if (ie_hit) begin
      rd_data[GPIO_CH-1:0] = ie_reg;
    end else if (gpio_hit) begin
      for (int c = 0; c < GPIO_CH; c++) begin
        if (gpio_off[31:2] == 30'(c)) begin
          case (gpio_off[1:0])
            2'd0:    rd_data[IO_W-1:0] = dir_all[c];
            2'd1:    rd_data[IO_W-1:0] = out_all[c];
            2'd2:    rd_data[IO_W-1:0] = in_all[c];
            default: rd_data[IO_W-1:0] = isr_all[c];
          endcase
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      o_D     <= '0;
      o_Valid <= 1'b0;
      o_Err   <= 1'b0;
      o_Irq   <= 1'b0;
    end else begin
      o_Valid <= rd_en;
      o_Err   <= (i_WE | i_RE) & ~mapped;
      o_Irq   <= |ch_irq;
      if (rd_en) o_D <= rd_data;
    end
  end
endmodule

// File: tb/tb_mmio_data_memory.sv
// Bench for mmio_data_memory: directed scenarios with literal expectations, then random
// traffic, all shadowed by a per-cycle behavioural model of the register map.
module tb_mmio_data_memory;
  localparam int DW = 32, DEPTH = 32, CH = 2, IOW = 32, BASE = 32;
  localparam int IE_A = BASE + 4 * CH;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic [31:0]       i_A = '0;
  logic              i_WE = 1'b0, i_RE = 1'b0;
  logic [DW-1:0]     i_D = '0;
  logic [DW-1:0]     o_D;
  logic              o_Valid, o_Err, o_Irq;
  logic [CH*IOW-1:0] i_Pin = '0;
  logic [CH*IOW-1:0] o_Pin, o_PinOE;

  mmio_data_memory #(.DATA_W(DW), .DEPTH(DEPTH), .GPIO_CH(CH), .IO_W(IOW), .GPIO_BASE(BASE)) dut (
    .Clk(Clk), .Reset(Reset), .i_A(i_A), .i_WE(i_WE), .i_RE(i_RE), .i_D(i_D),
    .o_D(o_D), .o_Valid(o_Valid), .o_Err(o_Err), .i_Pin(i_Pin),
    .o_Pin(o_Pin), .o_PinOE(o_PinOE), .o_Irq(o_Irq)
  );

  always #5 Clk = ~Clk;

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: register map contents plus the pin samples of the last three edges.
  logic [31:0]     m_ram [DEPTH];
  logic [IOW-1:0]  m_dir [CH], m_out [CH], m_isr [CH];
  logic [CH-1:0]   m_ie;
  logic [63:0]     p0, p1, p2;   // pin value sampled 1, 2 and 3 edges ago
  logic [31:0]     e_d;
  logic            e_valid, e_err, e_irq;

  function automatic bit m_mapped(input logic [31:0] a);
    return (a < DEPTH) || (a >= BASE && a <= IE_A);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int ch;
    if (a < DEPTH) return m_ram[a];
    if (a == IE_A) return {30'b0, m_ie};
    if (a >= BASE && a < IE_A) begin
      ch = int'(a - BASE) / 4;
      case (int'(a - BASE) % 4)
        0: return m_dir[ch];
        1: return m_out[ch];
        2: return p1[ch*IOW +: IOW];
        default: return m_isr[ch];
      endcase
    end
    return 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_ram[i] = '0;
    for (int c = 0; c < CH; c++) begin m_dir[c] = '0; m_out[c] = '0; m_isr[c] = '0; end
    m_ie = '0; p0 = '0; p1 = '0; p2 = '0;
    e_d = '0; e_valid = 0; e_err = 0; e_irq = 0;
  endtask

  task automatic model_step();
    logic [31:0] rd, clr, rise;
    logic irq_n;
    rd = m_read(i_A);
    irq_n = 0;
    for (int c = 0; c < CH; c++) if (m_ie[c] && m_isr[c] != 0) irq_n = 1;
    for (int c = 0; c < CH; c++) begin
      rise = p1[c*IOW +: IOW] & ~p2[c*IOW +: IOW] & ~m_dir[c];
      clr  = (i_WE && i_A == BASE + 4*c + 3) ? i_D : 32'h0;
      m_isr[c] = (m_isr[c] & ~clr) | rise;
    end
    if (i_WE) begin
      if (i_A < DEPTH) m_ram[i_A] = i_D;
      for (int c = 0; c < CH; c++) begin
        if (i_A == BASE + 4*c)     m_dir[c] = i_D;
        if (i_A == BASE + 4*c + 1) m_out[c] = i_D;
      end
      if (i_A == IE_A) m_ie = i_D[CH-1:0];
    end
    p2 = p1; p1 = p0; p0 = i_Pin;
    e_valid = i_RE && !i_WE;
    e_err   = (i_WE || i_RE) && !m_mapped(i_A);
    if (e_valid) e_d = rd;
    e_irq = irq_n;
  endtask

  always @(posedge Clk or posedge Reset) begin
    if (Reset) model_reset();
    else       model_step();
    #1;
    chk("o_D", 64'(o_D), 64'(e_d));
    chk("o_Valid", 64'(o_Valid), 64'(e_valid));
    chk("o_Err", 64'(o_Err), 64'(e_err));
    chk("o_Irq", 64'(o_Irq), 64'(e_irq));
    chk("o_Pin", o_Pin, {m_out[1], m_out[0]});
    chk("o_PinOE", o_PinOE, {m_dir[1], m_dir[0]});
  end

  task automatic op(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    @(negedge Clk);
    i_WE = we; i_RE = re; i_A = a; i_D = d;
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    int sel;
    logic [31:0] a;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;

    // Reset state reads back as zero.
    op(0, 1, 5, 0);
    op(0, 1, 32, 0);
    chk("lit_rd_ram5", {o_Valid, 32'(o_D)}, {1'b1, 32'h0});
    idle();
    chk("lit_rd_dir0", {o_Valid, 32'(o_D)}, {1'b1, 32'h0});
    chk("lit_rst_pins", {o_Pin, o_PinOE}, 128'h0);

    // RAM top word round trip, then DIR0 drives OE.
    op(1, 0, 31, 32'hDEADBEEF);
    op(0, 1, 31, 0);
    op(1, 0, 32, 32'h1);
    chk("lit_rd_ram31", {o_Valid, 32'(o_D)}, {1'b1, 32'hDEADBEEF});
    idle();
    chk("lit_oe0", 64'(o_PinOE[0]), 64'h1);

    op(1, 0, 33, 32'hA5);
    op(1, 0, 32, 32'hFF);
    idle();
    chk("lit_pin_a5", 64'(o_Pin[7:0]), 64'hA5);
    chk("lit_oe_ff", 64'(o_PinOE[7:0]), 64'hFF);

    // Edge capture latency and interrupt.
    op(1, 0, 32, 0);
    op(1, 0, IE_A, 1);
    idle(); idle();
    idle(); i_Pin = 64'h8;
    idle(); idle();
    op(0, 1, 35, 0);
    chk("lit_irq_early", 64'(o_Irq), 64'h0);
    op(1, 0, 35, 32'h8);
    chk("lit_isr_set", {o_Valid, 32'(o_D)}, {1'b1, 32'h8});
    chk("lit_irq_set", 64'(o_Irq), 64'h1);
    idle();
    chk("lit_irq_hold", 64'(o_Irq), 64'h1);
    idle();
    chk("lit_irq_clr", 64'(o_Irq), 64'h0);

    // Clear in the same cycle as a new edge: the set wins.
    idle(); i_Pin = 64'h0;
    repeat (4) idle();
    idle(); i_Pin = 64'h8;
    idle();
    op(1, 0, 35, 32'h8);
    op(0, 1, 35, 0);
    idle();
    chk("lit_set_wins", 64'(o_D), 64'h8);

    // Unmapped accesses and write-priority collision.
    op(0, 1, 32'h1000, 0);
    idle();
    chk("lit_unmapped_rd", {o_Err, o_Valid, 32'(o_D)}, {1'b1, 1'b1, 32'h0});
    op(1, 0, IE_A + 1, 32'h5);
    idle();
    chk("lit_unmapped_wr", {o_Err, o_Valid}, 2'b10);
    op(1, 1, 2, 32'h1234);
    idle();
    chk("lit_we_re", {o_Err, o_Valid}, 2'b00);
    op(0, 1, 2, 0);
    idle();
    chk("lit_we_re_data", 64'(o_D), 64'h1234);

    // Random traffic; the per-cycle model compare does the checking.
    for (int n = 0; n < 1500; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 4)      a = $urandom_range(0, DEPTH - 1);
      else if (sel < 8) a = $urandom_range(BASE, IE_A);
      else if (sel < 9) a = $urandom_range(IE_A + 1, IE_A + 10);
      else              a = $urandom;
      op(1'($urandom), 1'($urandom), a, $urandom);
      if ($urandom_range(0, 3) == 0) i_Pin = i_Pin ^ {$urandom & $urandom, $urandom & $urandom};
    end

    // Reset in the middle of a read with pins driven.
    idle(); i_Pin = 64'h0000_00F0_0000_000F;
    repeat (3) idle();
    op(0, 1, 5, 0);
    #2 Reset = 1'b1;
    #1;
    chk("lit_async_rst", {o_Valid, o_Err, o_Irq, 32'(o_D)}, 35'h0);
    chk("lit_async_rst_pins", {o_Pin, o_PinOE}, 128'h0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0; i_RE = 1'b0; i_WE = 1'b0;
    op(0, 1, 35, 0);
    chk("lit_no_valid_after_rst", 64'(o_Valid), 64'h0);
    idle();
    chk("lit_isr_after_rst", {o_Valid, 32'(o_D)}, {1'b1, 32'h0});
    repeat (2) idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
